// File: rtl/addsub_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Largest positive signed value of the given width; supports widths up to 64.
    function automatic logic [63:0] sat_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic int stage_count(input int width, input int chunk);
        return (chunk > 0) ? (width / chunk) : 1;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit ripple slice; c_msb is the carry into the slice MSB.
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign s      = w_full[CHUNK-1:0];
    assign cout   = w_full[CHUNK];
    // The sum bit is a^b^carry-in, so the carry into the MSB falls out of it.
    assign c_msb  = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor, one CHUNK-bit carry slice per stage,
// with valid/ready streaming, overflow/zero/carry flags and optional signed saturation.
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = stage_count(WIDTH, CHUNK);
    localparam int LAST   = STAGES - 1;
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    if ((CHUNK < 1) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
        $error("addsub_pipe: WIDTH must be >= 2 and an exact multiple of CHUNK >= 1");
    end

    // Stage k registers hold the beat after chunks 0..k are resolved; the last one drives the outputs.
    logic             r_v   [STAGES];
    logic             r_sat [STAGES];
    logic             r_c   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_vin   [STAGES];
    logic             w_satin [STAGES];
    logic             w_cin   [STAGES];
    logic [WIDTH-1:0] w_ain   [STAGES];
    logic [WIDTH-1:0] w_bin   [STAGES];
    logic [WIDTH-1:0] w_sin   [STAGES];
    logic [WIDTH-1:0] w_snext [STAGES];
    logic [CHUNK-1:0] w_cs    [STAGES];
    logic             w_cout  [STAGES];
    logic             w_cmsb  [STAGES];

    logic             w_en;
    logic             w_ovf_fin;
    logic [WIDTH-1:0] w_sum_fin;

    assign w_en     = !(r_v[LAST] && !out_ready);
    assign in_ready = w_en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CHUNK;
        localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << LO;

        if (k == 0) begin : g_head
            assign w_vin[k]   = in_valid;
            assign w_satin[k] = sat;
            assign w_ain[k]   = a;
            assign w_bin[k]   = (mode == MODE_SUB) ? ~b : b;
            assign w_cin[k]   = (mode == MODE_SUB);
            assign w_sin[k]   = '0;
        end else begin : g_body
            assign w_vin[k]   = r_v[k-1];
            assign w_satin[k] = r_sat[k-1];
            assign w_ain[k]   = r_a[k-1];
            assign w_bin[k]   = r_b[k-1];
            assign w_cin[k]   = r_c[k-1];
            assign w_sin[k]   = r_s[k-1];
        end

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (w_ain[k][LO +: CHUNK]),
            .b     (w_bin[k][LO +: CHUNK]),
            .cin   (w_cin[k]),
            .s     (w_cs[k]),
            .cout  (w_cout[k]),
            .c_msb (w_cmsb[k])
        );

        assign w_snext[k] = (w_sin[k] & ~MASK) | (WIDTH'(w_cs[k]) << LO);
    end

    // Overflow is taken before clamping so it reports the true arithmetic condition.
    assign w_ovf_fin = w_cout[LAST] ^ w_cmsb[LAST];
    assign w_sum_fin = (w_satin[LAST] && w_ovf_fin)
                     ? (w_ain[LAST][WIDTH-1] ? SAT_MIN : SAT_MAX)
                     : w_snext[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= 1'b0;
                r_sat[k] <= 1'b0;
                r_c[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
            end
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= w_vin[k];
                r_sat[k] <= w_satin[k];
                r_c[k]   <= w_cout[k];
                r_a[k]   <= w_ain[k];
                r_b[k]   <= w_bin[k];
                r_s[k]   <= (k == LAST) ? w_sum_fin : w_snext[k];
            end
            r_cout <= w_cout[LAST];
            r_ovf  <= w_ovf_fin;
            r_zero <= (w_sum_fin == '0);
        end
    end

    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed and streamed checks of addsub_pipe at WIDTH=16, CHUNK=4 (latency 4).
module tb_addsub_pipe;
    import addsub_pkg::*;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int LAT   = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    int          total = 0;
    int          bad = 0;
    int          waitCycles;
    logic        sawValid;
    logic [18:0] expQ[$];

    addsub_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result packed as {sum, cout, ovf, zero}; overflow uses the operand-sign rule.
    function automatic logic [18:0] model(input logic [15:0] ia, input logic [15:0] ib,
                                          input logic im, input logic is);
        logic [15:0] bx;
        logic [16:0] full;
        logic [15:0] res;
        logic        v;
        bx   = im ? ~ib : ib;
        full = {1'b0, ia} + {1'b0, bx} + {16'd0, im};
        res  = full[15:0];
        v    = (ia[15] == bx[15]) && (res[15] != ia[15]);
        if (is && v) res = ia[15] ? 16'h8000 : 16'h7FFF;
        return {res, full[16], v, (res == 16'h0000)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [15:0] eSum, input logic eCout,
                               input logic eOvf, input logic eZero);
        checkOutput({tag, ".sum"},  32'(sum),  32'(eSum));
        checkOutput({tag, ".cout"}, 32'(cout), 32'(eCout));
        checkOutput({tag, ".ovf"},  32'(ovf),  32'(eOvf));
        checkOutput({tag, ".zero"}, 32'(zero), 32'(eZero));
    endtask

    // Presents one beat, then waits (bounded) for the result and checks the latency.
    task automatic applyStimulus(input logic [15:0] ia, input logic [15:0] ib,
                                 input logic im, input logic is);
        @(negedge clk);
        a        = ia;
        b        = ib;
        mode     = im;
        sat      = is;
        in_valid = 1'b1;
        #1 checkOutput("in_ready_before_beat", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid   = 1'b0;
        waitCycles = 1;
        while (!out_valid && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("latency", 32'(waitCycles), 32'(LAT));
    endtask

    initial begin
        logic        holdBeat;
        logic        prevStall;
        logic [19:0] savedOut;
        int          sent;
        int          rcvd;
        int          cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        mode      = MODE_ADD;
        sat       = 1'b0;
        out_ready = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
        checkResult("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n    = 1'b1;
        sawValid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("idle_no_valid", 32'(sawValid), 32'd0);

        $display("[TB] directed vectors");
        applyStimulus(16'h1234, 16'h0FFF, MODE_ADD, 1'b0);
        checkResult("add_basic", 16'h2233, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, MODE_ADD, 1'b0);
        checkResult("add_wrap", 16'h0000, 1'b1, 1'b0, 1'b1);
        applyStimulus(16'h0005, 16'h0007, MODE_SUB, 1'b0);
        checkResult("sub_borrow", 16'hFFFE, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'h0001, MODE_SUB, 1'b0);
        checkResult("sub_ovf_nosat", 16'h7FFF, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h8000, 16'h0001, MODE_SUB, 1'b1);
        checkResult("sub_ovf_sat", 16'h8000, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, MODE_ADD, 1'b1);
        checkResult("add_pos_sat", 16'h7FFF, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h8000, 16'hFFFF, MODE_ADD, 1'b1);
        checkResult("add_neg_sat", 16'h8000, 1'b1, 1'b1, 1'b0);

        $display("[TB] random stream");
        holdBeat  = 1'b0;
        prevStall = 1'b0;
        savedOut  = '0;
        sent      = 0;
        rcvd      = 0;
        cyc       = 0;
        while (rcvd < 32 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (prevStall)
                checkOutput("stall_hold", 32'({out_valid, sum, cout, ovf, zero}), 32'(savedOut));
            if (!holdBeat) begin
                if (sent < 32 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    a        = 16'($urandom);
                    b        = 16'($urandom);
                    mode     = 1'($urandom_range(0, 1));
                    sat      = 1'($urandom_range(0, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checkOutput("in_ready_rule", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (out_valid && out_ready) begin
                checkOutput("result_expected", 32'(expQ.size() > 0), 32'd1);
                if (expQ.size() > 0) begin
                    checkOutput("stream_result", 32'({sum, cout, ovf, zero}), 32'(expQ.pop_front()));
                    rcvd++;
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(model(a, b, mode, sat));
                sent++;
                holdBeat = 1'b0;
            end else begin
                holdBeat = in_valid;
            end
            prevStall = out_valid && !out_ready;
            savedOut  = {out_valid, sum, cout, ovf, zero};
        end
        checkOutput("stream_count", 32'(rcvd), 32'd32);
        checkOutput("stream_leftover", 32'(expQ.size()), 32'd0);

        $display("[TB] reset with beats in flight");
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a        = 16'h0010 + 16'(i);
            b        = 16'h0100;
            mode     = MODE_ADD;
            sat      = 1'b0;
            in_valid = 1'b1;
            #1 checkOutput("fill_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        checkOutput("fill_stalled_valid", 32'(out_valid), 32'd1);
        checkOutput("fill_stalled_ready", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_reset.sum", 32'(sum), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        sawValid  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("post_reset_no_stale", 32'(sawValid), 32'd0);
        applyStimulus(16'h0001, 16'h0001, MODE_ADD, 1'b0);
        checkResult("post_reset_beat", 16'h0002, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
